conv2_k_mem_write: RTL

Convolution-2 layer weight-memory loader: the write-side counterpart of the conv2 kernel read counter. It accepts a stream of kernel weights from the host/Avalon bridge over a valid/ready handshake. Each weight is written into the conv2 weight RAM at sequential addresses 0..NKERN*KSIZE-1. This produces the layout the read side expects: the kernel block at addr0 and its partner block at addr0 + 75. The block sits between the host interface and the weight RAM write port, and raises `done` once the full weight set is resident.

---
 rtl/conv2_pkg.sv | 8 +
 rtl/conv2_k_wr_counter.sv | 41 ++++
 rtl/conv2_k_mem_write.sv | 94 +++++++++
 3 files changed

// File: rtl/conv2_pkg.sv
// Shared conv2 constants and the weight-loader FSM state type.
package conv2_pkg;
  localparam int KSIZE       = 25;
  localparam int NKERN       = 6;
  localparam int BANK_OFFSET = 75;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
endpackage

// File: rtl/conv2_k_wr_counter.sv
// Word address, tap and kernel index counters for the conv2 weight loader.
module conv2_k_wr_counter #(
  parameter int KSIZE  = 25,
  parameter int NKERN  = 6,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  output logic [ADDR_W-1:0] word_cnt,
  output logic [2:0]        kernel_idx,
  output logic              last_word
);
  localparam int TAP_W = $clog2(KSIZE);

  logic [TAP_W-1:0] tap_cnt;

  assign last_word = (word_cnt == ADDR_W'(NKERN*KSIZE-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt   <= '0;
      tap_cnt    <= '0;
      kernel_idx <= '0;
    end else if (clear) begin
      word_cnt   <= '0;
      tap_cnt    <= '0;
      kernel_idx <= '0;
    end else if (inc) begin
      word_cnt <= word_cnt + 1'b1;
      // kernel_idx advances as each kernel's last tap is taken
      if (tap_cnt == TAP_W'(KSIZE-1)) begin
        tap_cnt    <= '0;
        kernel_idx <= kernel_idx + 1'b1;
      end else begin
        tap_cnt <= tap_cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/conv2_k_mem_write.sv
// Streams conv2 kernel weights into the weight RAM at sequential addresses, then flags done.
// Optional CONV2_K_WR_CKSUM_EN adds a 16-bit wrapping checksum of accepted words.
module conv2_k_mem_write #(
  parameter int DATA_W = 16,
  parameter int KSIZE  = conv2_pkg::KSIZE,
  parameter int NKERN  = conv2_pkg::NKERN,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [2:0]        kernel_idx,
`ifdef CONV2_K_WR_CKSUM_EN
  output logic [15:0]       cksum,
`endif
  output logic              done
);
  import conv2_pkg::*;

  state_t            state, state_nxt;
  logic              clear;
  logic              accept;
  logic              last_word;
  logic [ADDR_W-1:0] word_cnt;

  assign in_ready = (state == LOAD);
  assign done     = (state == DONE);
  assign accept   = in_valid && in_ready;

  conv2_k_wr_counter #(
    .KSIZE (KSIZE),
    .NKERN (NKERN),
    .ADDR_W(ADDR_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .inc       (accept),
    .word_cnt  (word_cnt),
    .kernel_idx(kernel_idx),
    .last_word (last_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = LOAD;
          clear     = 1'b1;
        end
      end
      LOAD: begin
        if (accept && last_word) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address/data hold their last value between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= word_cnt;
        wr_data <= in_data;
      end
    end
  end

`ifdef CONV2_K_WR_CKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      cksum <= '0;
    else if (clear)  cksum <= '0;
    else if (accept) cksum <= cksum + 16'(in_data);
  end
`endif
endmodule
